// File: rtl/hash_req_arbiter_pkg.sv
// hash_req_arbiter_pkg: shared types for the hash core arbiter.
//   packet_input  - one 64-bit message word as seen by the hash core
//   packet_output - default-width (512-bit) digest word
//   arb_state_t   - arbiter FSM states
package hash_req_arbiter_pkg;
    localparam int WORD_W   = 64;
    localparam int DIGEST_W = 512;
    typedef logic [WORD_W-1:0]   packet_input;
    typedef logic [DIGEST_W-1:0] packet_output;
    typedef enum logic [2:0] {IDLE, RST, RST_GAP, STREAM, WAIT_OUT, RESULT} arb_state_t;
endpackage

// File: rtl/hash_req_arbiter_rr_pick.sv
// hash_req_arbiter_rr_pick: combinational round-robin finder.
//   i_req   [N-1:0]    request vector
//   i_last  [ID_W-1:0] index granted last time; search starts just after it
//   o_grant [ID_W-1:0] first requesting index found, wrapping around
//   o_any              at least one request is set
module hash_req_arbiter_rr_pick
    import hash_req_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_last,
    output logic [ID_W-1:0] o_grant,
    output logic            o_any
);
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        o_grant = '0;
        for (int k = N; k >= 1; k--)
            if (i_req[(int'(i_last) + k) % N]) o_grant = ID_W'((int'(i_last) + k) % N);
    end
    assign o_any = |i_req;
endmodule

// File: rtl/hash_req_arbiter.sv
// hash_req_arbiter: shares one hash core between N_REQ requesters, one message at a time.
// Each grant pulses core_reset, streams the winner's words with backpressure, waits for
// the digest (rising edge of core_out_ready) and returns it tagged with the requester ID.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/data/last/byte_num, req_ready   per-requester word streams
//   core_reset, core_in, core_in_ready, core_is_last, core_byte_num   to the hash core
//   core_buffer_full, core_out, core_out_ready                          from the hash core
//   res_valid, res_id, res_digest, res_err, res_ready                   result handshake
// Optional feature: define HASH_ARB_WATCHDOG_EN to bound the digest wait to TIMEOUT_CYC
// cycles; on expiry the result is returned with res_err=1 and a zero digest.
module hash_req_arbiter
    import hash_req_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int OUT_W       = 512,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WORD_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*3-1:0]      req_byte_num,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    core_reset,
    output packet_input             core_in,
    output logic                    core_in_ready,
    output logic                    core_is_last,
    output logic [2:0]              core_byte_num,
    input  logic                    core_buffer_full,
    input  logic [OUT_W-1:0]        core_out,
    input  logic                    core_out_ready,
    output logic                    res_valid,
    output logic [ID_W-1:0]         res_id,
    output logic [OUT_W-1:0]        res_digest,
    output logic                    res_err,
    input  logic                    res_ready
);
    arb_state_t       r_state, w_next;
    logic [ID_W-1:0]  r_gnt, r_rr, w_pick, r_res_id;
    logic [OUT_W-1:0] r_res_digest;
    logic             r_out_rdy_d, w_any, w_rise, w_xfer, w_timeout, w_done;

    hash_req_arbiter_rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
        .i_req   (req_valid),
        .i_last  (r_rr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // The delayed copy runs in every state, so a level already high when WAIT_OUT
    // is entered shows no edge and must drop and rise again to be accepted.
    assign w_rise = core_out_ready && !r_out_rdy_d;
    assign w_xfer = (r_state == STREAM) && req_valid[r_gnt] && !core_buffer_full;
    assign w_done = (r_state == WAIT_OUT) && (w_rise || w_timeout);

`ifdef HASH_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_res_err;
    // Held at zero outside WAIT_OUT, so it restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (reset || r_state != WAIT_OUT) r_wd_cnt <= '0;
        else r_wd_cnt <= r_wd_cnt + CNT_W'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) r_res_err <= 1'b0;
        else if (w_done) r_res_err <= !w_rise;
    end
    assign w_timeout = (r_state == WAIT_OUT) && !w_rise && (r_wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign res_err   = r_res_err;
`else
    assign w_timeout = 1'b0;
    assign res_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_any ? RST : IDLE;
            RST:      w_next = RST_GAP;
            RST_GAP:  w_next = STREAM;
            STREAM:   w_next = (w_xfer && req_last[r_gnt]) ? WAIT_OUT : STREAM;
            WAIT_OUT: w_next = w_done ? RESULT : WAIT_OUT;
            RESULT:   w_next = res_ready ? IDLE : RESULT;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt        <= '0;
            r_rr         <= ID_W'(N_REQ - 1);
            r_out_rdy_d  <= 1'b0;
            r_res_id     <= '0;
            r_res_digest <= '0;
        end else begin
            r_out_rdy_d <= core_out_ready;
            if (r_state == IDLE && w_any) begin
                r_gnt <= w_pick;
                r_rr  <= w_pick;
            end
            if (w_done) begin
                r_res_id     <= r_gnt;
                r_res_digest <= w_rise ? core_out : '0;
            end
        end
    end

    // Outputs are gated by reset so an abort takes effect in the same cycle.
    always_comb begin
        core_reset    = reset || (r_state == RST);
        core_in       = '0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        core_in_ready = 1'b0;
        req_ready     = '0;
        if (r_state == STREAM && !reset) begin
            core_in          = req_data[int'(r_gnt)*WORD_W +: WORD_W];
            core_is_last     = req_last[r_gnt];
            core_byte_num    = req_byte_num[int'(r_gnt)*3 +: 3];
            core_in_ready    = req_valid[r_gnt] && !core_buffer_full;
            req_ready[r_gnt] = !core_buffer_full;
        end
        res_valid = (r_state == RESULT) && !reset;
    end

    assign res_id     = r_res_id;
    assign res_digest = r_res_digest;
endmodule

// File: doc/hash_req_arbiter.md
Name: hash_req_arbiter

Overview:
- Shares one hash core (64-bit word input, buffer_full backpressure, out/out_ready result) between N_REQ requesters.
- Round-robin grant per message: pulses core reset, streams the granted requester's words with backpressure, waits for the digest, returns it tagged with requester ID.
- Sits between requester front-ends and the hash core; the core sees exactly one message at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of requester ID.
- OUT_W, 512, digest width (matches packet_output).
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  requester i presents a word.
- req_data  in  N_REQ*64  word per requester, packet_input.
- req_last  in  N_REQ  word is final of message.
- req_byte_num  in  N_REQ*3  valid bytes in final word; 0 on last = empty terminator.
- req_ready  out  N_REQ  word accepted when valid&ready.
- core_reset  out  1  core synchronous reset.
- core_in  out  64  word to core.
- core_in_ready  out  1  core_in valid this cycle.
- core_is_last  out  1  to core is_last.
- core_byte_num  out  3  to core byte_num.
- core_buffer_full  in  1  core backpressure.
- core_out  in  OUT_W  core digest.
- core_out_ready  in  1  digest valid; rising edge marks completion.
- res_valid  out  1  digest available.
- res_id  out  ID_W  requester owning digest.
- res_digest  out  OUT_W  captured digest.
- res_err  out  1  watchdog expiry flag.
- res_ready  in  1  downstream accepts result.

Behaviour:
- Reset: state IDLE; rr pointer = N_REQ-1; req_ready=0; core_in_ready=0; core_is_last=0; core_byte_num=0; core_in=0; core_reset=1 while reset high; res_valid=0, res_id=0, res_digest=0, res_err=0.
- FSM, IDLE -> RST: any req_valid; grant = first set bit searching from rr+1 with wrap; grant, rr registered.
- RST, one cycle: core_reset=1. Then RST_GAP, one cycle: core_reset=0. Then STREAM.
- STREAM:
  - core_in, core_is_last and core_byte_num are a combinational mux of the granted requester.
  - core_in_ready = req_valid[g] & ~core_buffer_full.
  - req_ready[g] = ~core_buffer_full; all other req_ready = 0.
  - Transfer = req_valid[g] & req_ready[g].
  - Transfer with req_last -> WAIT_OUT.
  - req_valid[g] low: bubble, core_in_ready=0, stay.
- WAIT_OUT:
  - core_in_ready=0.
  - Registered copy of core_out_ready; rise (cur=1, prev=0) -> capture core_out into res_digest, res_id=g, res_err=0, go RESULT.
  - A level already high on entry is not accepted until it falls and rises again.
- RESULT: res_valid=1, outputs stable; res_valid & res_ready -> IDLE next cycle; rr stays at g.
- Latency: req_valid in IDLE at cycle 0 -> core_reset high cycle 1 -> first possible transfer cycle 3.
- Requesters not granted are held (ready=0); no starvation: each requester is served within N_REQ-1 messages.
- Simultaneous req_valid on several lines: round-robin order only; no priority.
- reset mid-message: abort immediately to IDLE and discard any partial digest; core_reset is high so the core is also cleared.
- core_buffer_full rising in the same cycle as a last word: no transfer; the word repeats until accepted.

Optional Feature:
- Macro: HASH_ARB_WATCHDOG_EN.
- With it: a counter clears on WAIT_OUT entry and increments each WAIT_OUT cycle. At TIMEOUT_CYC-1 without a rise: go RESULT with res_err=1, res_digest=0, res_id=g.
- Without it: WAIT_OUT waits indefinitely; res_err tied 0; no counter logic.

Decomposition:
- Package defs: packet_input (64-bit), packet_output (OUT_W), state enum arb_state_t {IDLE, RST, RST_GAP, STREAM, WAIT_OUT, RESULT}.
- One sub-module: rr_pick (combinational round-robin finder; inputs request vector and last pointer; outputs grant index and any).

Test Plan:
- Req 0 sends 3 words, last byte_num=5 -> core sees core_reset pulse, 3 transfers, last with is_last=1/byte_num=5; digest D0 on out_ready rise -> res_id=0, res_digest=D0.
- Req 1 and 3 valid in the same IDLE cycle, rr=0 -> grant 1 first, then 3 after res_ready; req 3 req_ready=0 throughout req 1's message.
- core_buffer_full high 5 cycles mid-STREAM -> no transfers, core_in_ready=0, data held; resumes with no words lost or duplicated.
- 8-byte message: full word with byte_num=0/last=0, then zero word with last=1/byte_num=0 -> both forwarded in order.
- reset asserted in WAIT_OUT -> next cycle IDLE, res_valid=0; new request restarts with a core_reset pulse.
- With HASH_ARB_WATCHDOG_EN and TIMEOUT_CYC=16, no out_ready -> res_valid with res_err=1 exactly 16 cycles after WAIT_OUT entry.
